// File: rtl/adc_log_pkg.sv
// Shared definitions for the ADC logging path (adc_clk packer and wb_clk BRAM writer).
package adc_log_pkg;

    localparam int ADC_WORD_W = 32;
    localparam int ADC_NCH    = 4;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_PRESENT  = 2'b01;
    localparam logic [1:0] ST_WAIT_ACK = 2'b10;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser with synchronous active-high reset to 0.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) ff <= '0;
        else       ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/adc_frame_packer.sv
// Deserialises four modulator bitstreams into words, banks one frame and
// offers the words to the wb_clk side over a toggle req/ack handshake.
module adc_frame_packer
    import adc_log_pkg::*;
#(
    parameter int WORD_W      = ADC_WORD_W,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              adc_clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              adc_a,
    input  logic              adc_b,
    input  logic              adc_c,
    input  logic              adc_d,
    output logic [WORD_W-1:0] word_o,
    output logic [1:0]        chan_o,
    output logic              req_tgl_o,
    input  logic              ack_tgl_i,
    output logic              busy_o,
    output logic              overflow_o,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic [1:0]        state_o
);

    localparam int BW = $clog2(WORD_W);

    logic [WORD_W-1:0]  sh   [ADC_NCH];
    logic [WORD_W-1:0]  hold [ADC_NCH];
    logic [ADC_NCH-1:0] bits;
    logic [BW-1:0]      bit_ctr;
    logic               frame_done;
    logic               ack_sync;
    logic               last_ack;
    logic [1:0]         state;
    logic [1:0]         chan;

    assign bits       = {adc_d, adc_c, adc_b, adc_a};
    assign frame_done = enable_i && (bit_ctr == BW'(WORD_W - 1));
    assign last_ack   = (state == ST_WAIT_ACK) && (ack_sync == req_tgl_o)
                        && (chan == CH_D);
    assign state_o    = state;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (adc_clk),
        .reset (reset),
        .d     (ack_tgl_i),
        .q     (ack_sync)
    );

    // LSB-first shift: the oldest sample lands in bit 0 once a word is full
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            bit_ctr <= '0;
            for (int i = 0; i < ADC_NCH; i++) begin
                sh[i]   <= '0;
                hold[i] <= '0;
            end
        end else if (enable_i) begin
            bit_ctr <= frame_done ? '0 : bit_ctr + BW'(1);
            for (int i = 0; i < ADC_NCH; i++) begin
                sh[i] <= {bits[i], sh[i][WORD_W-1:1]};
                if (frame_done && !busy_o)
                    hold[i] <= {bits[i], sh[i][WORD_W-1:1]};
            end
        end else begin
            bit_ctr <= '0;
        end
    end

    // A frame landing on the last-ack edge still sees busy_o=1 and is dropped
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            busy_o      <= 1'b0;
            overflow_o  <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            if (frame_done && !busy_o) begin
                busy_o      <= 1'b1;
                frame_cnt_o <= frame_cnt_o + CNT_W'(1);
            end else if (last_ack) begin
                busy_o <= 1'b0;
            end
            if (frame_done && busy_o)
                overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            chan      <= CH_A;
            word_o    <= '0;
            chan_o    <= CH_A;
            req_tgl_o <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (busy_o) begin
                        state <= ST_PRESENT;
                        chan  <= CH_A;
                    end
                end
                ST_PRESENT: begin
                    word_o    <= hold[chan];
                    chan_o    <= chan;
                    req_tgl_o <= ~req_tgl_o;
                    state     <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack_sync == req_tgl_o) begin
                        if (chan == CH_D) begin
                            state <= ST_IDLE;
                        end else begin
                            chan  <= chan + 2'd1;
                            state <= ST_PRESENT;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
